uart_operand_link: RTL and testbench

- UART endpoint of the peripheral subsystem, 8N1 framing, runs on the peripheral clock.
- Receives two consecutive bytes from the host as operands a then b, and flags ready.
- Transmits the CPU-computed result byte when tx_en rises.
- Its a/b/ready outputs are read by the bus peripheral. That peripheral drives result and tx_en from memory-mapped registers.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rx.sv | 121 ++++++++++++
 rtl/uart_operand_link.sv | 168 ++++++++++++++++
 tb/tb_uart_operand_link.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the UART operand link: FSM state encodings, data width, operand pointer.
// State codes are 3 bits so they stay identical whether or not UART_PARITY_EN adds the PARITY state.
package uart_pkg;

  localparam int DATA_BITS = 8;

  localparam logic OP_A = 1'b0;
  localparam logic OP_B = 1'b1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

endpackage

// File: rtl/uart_rx.sv
// UART receiver: din synchronizer, frame decoder and a one-cycle strobe per accepted byte.
// With UART_PARITY_EN defined the frame is 8E1 and a parity mismatch discards the byte.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10416,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 din,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF     = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   rx_bit;
  logic [2:0]             state_reg;
  logic [CW-1:0]          cnt_reg;
  logic [2:0]             bit_reg;
  logic [DATA_BITS-1:0]   shift_reg;
  logic                   valid_reg;
  logic                   stop_ok;

  // Synchronizer resets to idle-high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_reg <= '1;
    end else begin
      sync_reg[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_reg[i] <= sync_reg[i-1];
      end
    end
  end

  assign rx_bit = sync_reg[SYNC_STAGES-1];

`ifdef UART_PARITY_EN
  logic parity_ok_reg;
  assign stop_ok = rx_bit & parity_ok_reg;
`else
  assign stop_ok = rx_bit;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      bit_reg       <= '0;
      shift_reg     <= '0;
      valid_reg     <= 1'b0;
`ifdef UART_PARITY_EN
      parity_ok_reg <= 1'b0;
`endif
    end else begin
      valid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          cnt_reg <= '0;
          if (!rx_bit) state_reg <= ST_START;
        end
        ST_START: begin
          if (cnt_reg == HALF) begin
            cnt_reg   <= '0;
            bit_reg   <= '0;
            state_reg <= rx_bit ? ST_IDLE : ST_DATA;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        ST_DATA: begin
          if (cnt_reg == LAST) begin
            cnt_reg   <= '0;
            shift_reg <= {rx_bit, shift_reg[DATA_BITS-1:1]};
            bit_reg   <= bit_reg + 3'd1;
            if (bit_reg == LAST_BIT) begin
`ifdef UART_PARITY_EN
              state_reg <= ST_PARITY;
`else
              state_reg <= ST_STOP;
`endif
            end
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
`ifdef UART_PARITY_EN
        ST_PARITY: begin
          if (cnt_reg == LAST) begin
            cnt_reg       <= '0;
            parity_ok_reg <= (rx_bit == ^shift_reg);
            state_reg     <= ST_STOP;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
`endif
        ST_STOP: begin
          if (cnt_reg == LAST) begin
            cnt_reg   <= '0;
            valid_reg <= stop_ok;
            state_reg <= ST_IDLE;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign data  = shift_reg;
  assign valid = valid_reg;

endmodule

// File: rtl/uart_operand_link.sv
// UART endpoint: collects host bytes as operand pair a/b with a ready flag, and sends result on a tx_en rise.
// Define UART_PARITY_EN for 8E1 framing on both directions (default 8N1).
module uart_operand_link
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10416,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 din,
  output logic                 dout,
  input  logic [DATA_BITS-1:0] result,
  input  logic                 tx_en,
  output logic [DATA_BITS-1:0] a,
  output logic [DATA_BITS-1:0] b,
  output logic                 ready
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_rx (
    .clk    (clk),
    .reset_n(reset_n),
    .din    (din),
    .data   (rx_data),
    .valid  (rx_valid)
  );

  logic [2:0]           tx_state_reg;
  logic [CW-1:0]        tx_cnt_reg;
  logic [2:0]           tx_bit_reg;
  logic [DATA_BITS-1:0] tx_shift_reg;
  logic                 dout_reg;
  logic                 tx_en_prev_reg;
  logic                 tx_start;
  logic                 tx_baud_done;

  logic [DATA_BITS-1:0] a_reg;
  logic [DATA_BITS-1:0] b_reg;
  logic                 ptr_reg;
  logic                 ready_reg;

  // Only a rise seen while idle starts a frame; rises during a frame are dropped.
  assign tx_start     = tx_en & ~tx_en_prev_reg & (tx_state_reg == ST_IDLE);
  assign tx_baud_done = (tx_cnt_reg == LAST);

`ifdef UART_PARITY_EN
  logic tx_parity_reg;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state_reg   <= ST_IDLE;
      tx_cnt_reg     <= '0;
      tx_bit_reg     <= '0;
      tx_shift_reg   <= '0;
      dout_reg       <= 1'b1;
      tx_en_prev_reg <= 1'b0;
`ifdef UART_PARITY_EN
      tx_parity_reg  <= 1'b0;
`endif
    end else begin
      tx_en_prev_reg <= tx_en;
      case (tx_state_reg)
        ST_IDLE: begin
          tx_cnt_reg <= '0;
          dout_reg   <= 1'b1;
          if (tx_start) begin
            tx_shift_reg  <= result;
`ifdef UART_PARITY_EN
            tx_parity_reg <= ^result;
`endif
            dout_reg      <= 1'b0;
            tx_state_reg  <= ST_START;
          end
        end
        ST_START: begin
          if (tx_baud_done) begin
            tx_cnt_reg   <= '0;
            tx_bit_reg   <= '0;
            dout_reg     <= tx_shift_reg[0];
            tx_state_reg <= ST_DATA;
          end else begin
            tx_cnt_reg <= tx_cnt_reg + CW'(1);
          end
        end
        ST_DATA: begin
          if (tx_baud_done) begin
            tx_cnt_reg   <= '0;
            tx_bit_reg   <= tx_bit_reg + 3'd1;
            tx_shift_reg <= {1'b0, tx_shift_reg[DATA_BITS-1:1]};
            if (tx_bit_reg == LAST_BIT) begin
`ifdef UART_PARITY_EN
              dout_reg     <= tx_parity_reg;
              tx_state_reg <= ST_PARITY;
`else
              dout_reg     <= 1'b1;
              tx_state_reg <= ST_STOP;
`endif
            end else begin
              dout_reg <= tx_shift_reg[1];
            end
          end else begin
            tx_cnt_reg <= tx_cnt_reg + CW'(1);
          end
        end
`ifdef UART_PARITY_EN
        ST_PARITY: begin
          if (tx_baud_done) begin
            tx_cnt_reg   <= '0;
            dout_reg     <= 1'b1;
            tx_state_reg <= ST_STOP;
          end else begin
            tx_cnt_reg <= tx_cnt_reg + CW'(1);
          end
        end
`endif
        ST_STOP: begin
          if (tx_baud_done) begin
            tx_cnt_reg   <= '0;
            tx_state_reg <= ST_IDLE;
          end else begin
            tx_cnt_reg <= tx_cnt_reg + CW'(1);
          end
        end
        default: tx_state_reg <= ST_IDLE;
      endcase
    end
  end

  // A transmit start wins over a same-cycle b commit, so ready ends low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      ptr_reg   <= OP_A;
      ready_reg <= 1'b0;
    end else begin
      if (rx_valid) begin
        if (ptr_reg == OP_A) begin
          a_reg     <= rx_data;
          ptr_reg   <= OP_B;
          ready_reg <= 1'b0;
        end else begin
          b_reg     <= rx_data;
          ptr_reg   <= OP_A;
          ready_reg <= 1'b1;
        end
      end
      if (tx_start) ready_reg <= 1'b0;
    end
  end

  assign dout  = dout_reg;
  assign a     = a_reg;
  assign b     = b_reg;
  assign ready = ready_reg;

endmodule

// File: tb/tb_uart_operand_link.sv
// Bench for uart_operand_link: random and directed frames checked against a byte-level operand model.
// Build with UART_PARITY_EN defined to exercise 8E1 framing.
module tb_uart_operand_link;

  localparam int CPB  = 16;
  localparam int SYNC = 2;
`ifdef UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int GAP = 2 * CPB;
  // negedge index (from start-bit drive) where ready first reads high
  localparam int READY_K = SYNC + 1 + CPB / 2 + (NBITS - 1) * CPB + 1;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       din = 1'b1;
  logic       dout;
  logic [7:0] result = 8'h00;
  logic       tx_en = 1'b0;
  logic [7:0] a;
  logic [7:0] b;
  logic       ready;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_a = 8'h00;
  logic [7:0] exp_b = 8'h00;
  logic       exp_ready = 1'b0;
  logic       exp_ptr_b = 1'b0;

  uart_operand_link #(
    .CLKS_PER_BIT(CPB),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .din    (din),
    .dout   (dout),
    .result (result),
    .tx_en  (tx_en),
    .a      (a),
    .b      (b),
    .ready  (ready)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] frame_bits(input logic [7:0] d, input logic par, input logic stop);
    logic [10:0] f;
    f = '1;
    f[0] = 1'b0;
    f[8:1] = d;
`ifdef UART_PARITY_EN
    f[9] = par;
    f[10] = stop;
`else
    f[9] = stop;
`endif
    return f;
  endfunction

  function automatic void model_rx(input logic [7:0] d, input logic ok);
    if (!ok) return;
    if (!exp_ptr_b) begin
      exp_a = d; exp_ptr_b = 1'b1; exp_ready = 1'b0;
    end else begin
      exp_b = d; exp_ptr_b = 1'b0; exp_ready = 1'b1;
    end
  endfunction

  function automatic void model_reset();
    exp_a = 8'h00; exp_b = 8'h00; exp_ready = 1'b0; exp_ptr_b = 1'b0;
  endfunction

  // Drives one frame plus idle gap on din, reports the first negedge index where ready reads 1.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, output int ready_k);
    logic [10:0] f;
    f = frame_bits(d, par, stop);
    ready_k = -1;
    for (int k = 0; k < NBITS * CPB + GAP; k++) begin
      @(negedge clk);
      if (ready_k < 0 && ready === 1'b1) ready_k = k;
      din = (k < NBITS * CPB) ? f[k / CPB] : 1'b1;
    end
    model_rx(d, stop && (NBITS == 10 || par == ^d));
  endtask

  // Sends one byte through tx_en, checking dout every cycle; optionally re-pulses tx_en mid-frame.
  task automatic tx_frame(input logic [7:0] d, input int repulse_k, input string tag);
    logic [10:0] f;
    logic        want;
    f = frame_bits(d, ^d, 1'b1);
    @(negedge clk);
    result = d;
    tx_en = 1'b1;
    exp_ready = 1'b0;
    for (int k = 1; k <= NBITS * CPB + GAP; k++) begin
      @(negedge clk);
      want = (k <= NBITS * CPB) ? f[(k - 1) / CPB] : 1'b1;
      total++;
      if (dout !== want) begin
        bad++;
        $display("FAIL %s_dout k=%0d got=%b want=%b", tag, k, dout, want);
      end
      if (k == 1) begin
        total++;
        if (ready !== 1'b0) begin
          bad++;
          $display("FAIL %s_ready_clear got=%b want=0", tag, ready);
        end
      end
      if (repulse_k > 0 && k == repulse_k) tx_en = 1'b0;
      if (repulse_k > 0 && k == repulse_k + 2) begin
        tx_en = 1'b1;
        result = 8'hFF;
      end
    end
    tx_en = 1'b0;
    $display("tx %s byte=%02h done", tag, d);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (dout !== 1'b1) begin bad++; $display("FAIL reset_dout got=%b want=1", dout); end
    total++; if (a !== 8'h00) begin bad++; $display("FAIL reset_a got=%02h want=00", a); end
    total++; if (b !== 8'h00) begin bad++; $display("FAIL reset_b got=%02h want=00", b); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", ready); end
    reset_n = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    $display("reset checked");
  endtask

  task automatic test_rx_pair();
    int rk;
    send_frame(8'h35, ^8'h35, 1'b1, rk);
    total++; if (a !== exp_a) begin bad++; $display("FAIL pair_a got=%02h want=%02h", a, exp_a); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL pair_ready_mid got=%b want=0", ready); end
    send_frame(8'hA2, ^8'hA2, 1'b1, rk);
    total++; if (rk !== READY_K) begin bad++; $display("FAIL pair_ready_time got=%0d want=%0d", rk, READY_K); end
    total++; if (b !== exp_b) begin bad++; $display("FAIL pair_b got=%02h want=%02h", b, exp_b); end
    total++; if (ready !== exp_ready) begin bad++; $display("FAIL pair_ready got=%b want=%b", ready, exp_ready); end
    repeat (3 * CPB) @(negedge clk);
    total++; if (a !== exp_a || b !== exp_b) begin
      bad++; $display("FAIL pair_stable got=%02h/%02h want=%02h/%02h", a, b, exp_a, exp_b);
    end
    $display("rx pair a=%02h b=%02h ready=%b", a, b, ready);
  endtask

  task automatic test_tx_basic();
    tx_frame(8'h5C, -1, "basic");
  endtask

  task automatic test_framing_error();
    int rk;
    send_frame(8'h77, ^8'h77, 1'b1, rk);
    send_frame(8'h99, ^8'h99, 1'b0, rk);
    total++; if (b !== exp_b) begin bad++; $display("FAIL frame_err_b got=%02h want=%02h", b, exp_b); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL frame_err_ready got=%b want=0", ready); end
    send_frame(8'h11, ^8'h11, 1'b1, rk);
    total++; if (a !== exp_a || b !== exp_b) begin
      bad++; $display("FAIL frame_err_recover got=%02h/%02h want=%02h/%02h", a, b, exp_a, exp_b);
    end
    total++; if (ready !== exp_ready) begin bad++; $display("FAIL frame_err_ready2 got=%b want=%b", ready, exp_ready); end
    $display("framing error a=%02h b=%02h ready=%b", a, b, ready);
  endtask

  task automatic test_glitch();
    @(negedge clk);
    din = 1'b0;
    repeat (5) @(negedge clk);
    din = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    total++; if (a !== exp_a || b !== exp_b || ready !== exp_ready) begin
      bad++; $display("FAIL glitch got=%02h/%02h/%b want=%02h/%02h/%b", a, b, ready, exp_a, exp_b, exp_ready);
    end
    $display("glitch a=%02h b=%02h", a, b);
  endtask

  task automatic test_tx_repulse();
    tx_frame(8'h96, 70, "repulse");
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic       stop, par;
    int         rk;
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      par = (^d) ^ ($urandom_range(0, 3) == 0);
      send_frame(d, par, stop, rk);
      total++; if (a !== exp_a || b !== exp_b || ready !== exp_ready) begin
        bad++; $display("FAIL rand_rx%0d got=%02h/%02h/%b want=%02h/%02h/%b", i, a, b, ready, exp_a, exp_b, exp_ready);
      end
      $display("rand rx %0d byte=%02h stop=%b par=%b a=%02h b=%02h", i, d, stop, par, a, b);
    end
    for (int i = 0; i < 2; i++) tx_frame(8'($urandom), -1, "rand");
  endtask

  task automatic test_full_duplex();
    logic [7:0] d0, d1, dt;
    int rk0, rk1;
    d0 = 8'($urandom_range(1, 255));
    d1 = 8'($urandom_range(1, 255));
    dt = 8'($urandom);
    if (exp_ptr_b) send_frame(8'h5A, ^8'h5A, 1'b1, rk0);
    fork
      begin
        send_frame(d0, ^d0, 1'b1, rk0);
        send_frame(d1, ^d1, 1'b1, rk1);
      end
      begin
        repeat (200) @(negedge clk);
        tx_frame(dt, 150, "duplex");
      end
    join
    total++; if (a !== exp_a || b !== exp_b) begin
      bad++; $display("FAIL duplex_ab got=%02h/%02h want=%02h/%02h", a, b, exp_a, exp_b);
    end
    total++; if (ready !== exp_ready) begin bad++; $display("FAIL duplex_ready got=%b want=%b", ready, exp_ready); end
    $display("duplex a=%02h b=%02h ready=%b", a, b, ready);
  endtask

  task automatic test_reset_mid_frame();
    logic [10:0] f;
    logic [7:0]  d0, d1;
    int          rk;
    f = frame_bits(8'hC3, ^8'hC3, 1'b1);
    fork
      begin
        for (int k = 0; k < 60; k++) begin
          @(negedge clk);
          din = f[k / CPB];
        end
      end
      begin
        @(negedge clk);
        result = 8'h00;
        tx_en = 1'b1;
        repeat (59) @(negedge clk);
      end
    join
    #2;
    total++; if (dout !== 1'b0) begin bad++; $display("FAIL mid_tx_dout got=%b want=0", dout); end
    reset_n = 1'b0;
    #1;
    total++; if (dout !== 1'b1) begin bad++; $display("FAIL mid_reset_dout got=%b want=1", dout); end
    total++; if (a !== 8'h00 || b !== 8'h00 || ready !== 1'b0) begin
      bad++; $display("FAIL mid_reset_out got=%02h/%02h/%b want=00/00/0", a, b, ready);
    end
    model_reset();
    tx_en = 1'b0;
    din = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    d0 = 8'($urandom);
    d1 = 8'($urandom);
    send_frame(d0, ^d0, 1'b1, rk);
    send_frame(d1, ^d1, 1'b1, rk);
    total++; if (a !== exp_a || b !== exp_b || ready !== 1'b1) begin
      bad++; $display("FAIL post_reset_pair got=%02h/%02h/%b want=%02h/%02h/1", a, b, ready, exp_a, exp_b);
    end
    $display("mid-frame reset, new pair a=%02h b=%02h", a, b);
  endtask

`ifdef UART_PARITY_EN
  task automatic test_parity();
    int rk;
    if (exp_ptr_b) send_frame(8'h5A, ^8'h5A, 1'b1, rk);
    send_frame(8'h07, 1'b1, 1'b1, rk);
    total++; if (a !== 8'h07) begin bad++; $display("FAIL parity_good got=%02h want=07", a); end
    send_frame(8'h07, 1'b0, 1'b1, rk);
    total++; if (b !== exp_b || ready !== 1'b0) begin
      bad++; $display("FAIL parity_bad got=%02h/%b want=%02h/0", b, ready, exp_b);
    end
    tx_frame(8'h03, -1, "parity");
    $display("parity a=%02h b=%02h", a, b);
  endtask
`endif

  initial begin
    test_reset();
    test_rx_pair();
    test_tx_basic();
    test_framing_error();
    test_glitch();
    test_tx_repulse();
    test_random();
    test_full_duplex();
    test_reset_mid_frame();
`ifdef UART_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
